// File: rtl/exec_mem_unit.sv
// Execute/memory slice: operand forwarding, ALU, Z/C flags and 256x8 data memory.
// ALU and reads are combinational; flags and writes update on clk; no backpressure.
module exec_mem_unit #(
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    fwd_a,
  input  logic [1:0]    fwd_b,
  input  logic [DW-1:0] reg_a,
  input  logic [DW-1:0] reg_b,
  input  logic [DW-1:0] ex_fwd,
  input  logic [DW-1:0] mem_fwd,
  input  logic [DW-1:0] imm,
  input  logic [2:0]    shamt,
  input  logic          alu_src,
  input  logic          is_shift,
  input  logic          update_z_c,
  input  logic [2:0]    acode,
  input  logic [1:0]    scode,
  output logic [DW-1:0] alu_result,
  output logic          alu_carry,
  output logic          zero,
  output logic          carry,
  input  logic [7:0]    mem_addr,
  input  logic [DW-1:0] store_data,
  input  logic [DW-1:0] store_fwd,
  input  logic          store_sel,
  input  logic          mem_read,
  input  logic          mem_write,
  output logic [DW-1:0] mem_rdata
);

  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [DW-1:0]   fwd_b_val;
  logic [DW:0]     arith;
  logic [DW:0]     shl_full;
  logic [DW:0]     shr_full;
  logic [2*DW-1:0] rol_full;
  logic [2*DW-1:0] ror_full;
  logic [2:0]      n;
  logic [DW-1:0]   mem [DEPTH];

  always_comb begin
    case (fwd_a)
      2'b01:   op_a = ex_fwd;
      2'b10:   op_a = mem_fwd;
      default: op_a = reg_a;
    endcase
    case (fwd_b)
      2'b01:   fwd_b_val = ex_fwd;
      2'b10:   fwd_b_val = mem_fwd;
      default: fwd_b_val = reg_b;
    endcase
    if (alu_src)
      op_b = imm;
    else if (is_shift)
      op_b = {{(DW-3){1'b0}}, shamt};
    else
      op_b = fwd_b_val;
  end

  always_comb begin
    arith      = '0;
    alu_result = '0;
    alu_carry  = carry;
    n          = op_b[2:0];
    shl_full   = {1'b0, op_a} << n;
    shr_full   = {op_a, 1'b0} >> n;
    rol_full   = {op_a, op_a} << n;
    ror_full   = {op_a, op_a} >> n;
    if (!is_shift) begin
      // Subtraction in DW+1 bits leaves the borrow in the top bit.
      case (acode)
        3'b000:  arith = {1'b0, op_a} + {1'b0, op_b};
        3'b001:  arith = {1'b0, op_a} + {1'b0, op_b} + {{DW{1'b0}}, carry};
        3'b010:  arith = {1'b0, op_a} - {1'b0, op_b};
        3'b011:  arith = {1'b0, op_a} - {1'b0, op_b} - {{DW{1'b0}}, carry};
        3'b100:  arith = {carry, op_a & op_b};
        3'b101:  arith = {carry, op_a | op_b};
        3'b110:  arith = {carry, op_a ^ op_b};
        default: arith = {carry, op_a & ~op_b};
      endcase
      alu_result = arith[DW-1:0];
      alu_carry  = arith[DW];
    end else if (n == 3'd0) begin
      alu_result = op_a;
    end else begin
      case (scode)
        2'b00: begin
          alu_result = shl_full[DW-1:0];
          alu_carry  = shl_full[DW];
        end
        2'b01: begin
          alu_result = shr_full[DW:1];
          alu_carry  = shr_full[0];
        end
        2'b10:   alu_result = rol_full[2*DW-1:DW];
        default: alu_result = ror_full[DW-1:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (update_z_c) begin
      zero  <= (alu_result == '0);
      carry <= alu_carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_write) begin
      mem[mem_addr] <= store_sel ? store_fwd : store_data;
    end
  end

  assign mem_rdata = mem_read ? mem[mem_addr] : '0;

endmodule

// File: tb/tb_exec_mem_unit.sv
// Randomized and directed bench for exec_mem_unit against an integer-arithmetic model.
module tb_exec_mem_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fwd_a, fwd_b;
  logic [7:0] reg_a, reg_b, ex_fwd, mem_fwd, imm;
  logic [2:0] shamt;
  logic       alu_src, is_shift, update_z_c;
  logic [2:0] acode;
  logic [1:0] scode;
  logic [7:0] alu_result;
  logic       alu_carry, zero, carry;
  logic [7:0] mem_addr, store_data, store_fwd;
  logic       store_sel, mem_read, mem_write;
  logic [7:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int mz, mc;
  int mm [256];

  always #5 clk = ~clk;

  exec_mem_unit dut (
    .clk(clk), .rst(rst), .fwd_a(fwd_a), .fwd_b(fwd_b), .reg_a(reg_a), .reg_b(reg_b),
    .ex_fwd(ex_fwd), .mem_fwd(mem_fwd), .imm(imm), .shamt(shamt), .alu_src(alu_src),
    .is_shift(is_shift), .update_z_c(update_z_c), .acode(acode), .scode(scode),
    .alu_result(alu_result), .alu_carry(alu_carry), .zero(zero), .carry(carry),
    .mem_addr(mem_addr), .store_data(store_data), .store_fwd(store_fwd),
    .store_sel(store_sel), .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Operation semantics written as plain integer arithmetic.
  function automatic void ref_alu(input int a, input int b, input int c, input bit sh,
                                  input int ac, input int sc, output int r, output int co);
    int s, n;
    r = 0; co = c;
    if (!sh) begin
      case (ac)
        0: s = a + b;
        1: s = a + b + c;
        2: s = a - b;
        3: s = a - b - c;
        4: s = a & b;
        5: s = a | b;
        6: s = a ^ b;
        default: s = a & (~b & 255);
      endcase
      r = s & 255;
      if (ac < 2) co = (s > 255) ? 1 : 0;
      else if (ac < 4) co = (s < 0) ? 1 : 0;
    end else begin
      n = b % 8;
      if (n == 0) r = a;
      else case (sc)
        0: begin r = (a << n) & 255; co = (a >> (8 - n)) & 1; end
        1: begin r = a >> n;         co = (a >> (n - 1)) & 1; end
        2: r = ((a << n) | (a >> (8 - n))) & 255;
        default: r = ((a >> n) | (a << (8 - n))) & 255;
      endcase
    end
  endfunction

  task automatic clear_inputs();
    fwd_a = 0; fwd_b = 0; reg_a = 0; reg_b = 0; ex_fwd = 0; mem_fwd = 0; imm = 0;
    shamt = 0; alu_src = 0; is_shift = 0; update_z_c = 0; acode = 0; scode = 0;
    mem_addr = 0; store_data = 0; store_fwd = 0; store_sel = 0; mem_read = 0; mem_write = 0;
  endtask

  // Inputs are set after a falling edge; check, clock once, advance model.
  task automatic do_cycle(input string tag);
    int a, bs, b, r, co;
    #1;
    case (fwd_a) 2'b01: a = ex_fwd; 2'b10: a = mem_fwd; default: a = reg_a; endcase
    case (fwd_b) 2'b01: bs = ex_fwd; 2'b10: bs = mem_fwd; default: bs = reg_b; endcase
    b = alu_src ? int'(imm) : is_shift ? int'(shamt) : bs;
    ref_alu(a, b, mc, is_shift, acode, scode, r, co);
    check_eq({tag, ".res"}, alu_result, r);
    check_eq({tag, ".cout"}, alu_carry, co);
    check_eq({tag, ".z"}, zero, mz);
    check_eq({tag, ".c"}, carry, mc);
    check_eq({tag, ".rdata"}, mem_rdata, mem_read ? mm[mem_addr] : 0);
    @(posedge clk);
    if (update_z_c) begin mz = (r == 0) ? 1 : 0; mc = co; end
    if (mem_write) mm[mem_addr] = store_sel ? store_fwd : store_data;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = 0;
    mz = 0; mc = 0;
    clear_inputs();
    rst = 1'b1;
    mem_read = 1; mem_addr = 8'h10;
    #3;
    check_eq("reset.z", zero, 0);
    check_eq("reset.c", carry, 0);
    check_eq("reset.rdata", mem_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();

    reg_a = 1; ex_fwd = 2; mem_fwd = 3; alu_src = 1; imm = 0;
    for (int f = 0; f < 4; f++) begin
      fwd_a = f[1:0];
      #1;
      check_eq("fwd.literal", alu_result, (f == 1) ? 2 : (f == 2) ? 3 : 1);
      do_cycle("fwd");
    end

    clear_inputs();
    reg_a = 8'hFF; alu_src = 1; imm = 8'h01; update_z_c = 1;
    do_cycle("add_ff");
    reg_a = 0; imm = 0; acode = 3'b001; update_z_c = 0;
    #1;
    check_eq("addc.flags", {zero, carry}, 2'b11);
    check_eq("addc.literal", alu_result, 1);
    do_cycle("addc");

    reg_a = 3; imm = 5; acode = 3'b010; update_z_c = 1;
    #1;
    check_eq("sub.literal", {alu_carry, alu_result}, 9'h1FE);
    do_cycle("sub");
    reg_a = 5; imm = 2; acode = 3'b011; update_z_c = 0;
    do_cycle("subc");

    clear_inputs();
    reg_a = 8'h81; is_shift = 1; shamt = 1;
    for (int s = 0; s < 4; s++) begin
      scode = s[1:0];
      do_cycle("shift");
    end

    clear_inputs();
    mem_write = 1; mem_addr = 8'h10; store_data = 8'h5A; store_fwd = 8'h33;
    do_cycle("wr0");
    mem_addr = 8'h11; store_sel = 1; store_data = 8'h44; store_fwd = 8'hA5;
    do_cycle("wr1");
    mem_write = 0; mem_read = 1; mem_addr = 8'h10;
    #1 check_eq("rd10.literal", mem_rdata, 8'h5A);
    do_cycle("rd10");
    mem_addr = 8'h11;
    #1 check_eq("rd11.literal", mem_rdata, 8'hA5);
    do_cycle("rd11");
    mem_read = 0;
    do_cycle("rd_off");

    for (int k = 0; k < 400; k++) begin
      fwd_a = 2'($urandom); fwd_b = 2'($urandom);
      reg_a = 8'($urandom); reg_b = 8'($urandom); ex_fwd = 8'($urandom);
      mem_fwd = 8'($urandom); imm = 8'($urandom); shamt = 3'($urandom);
      alu_src = ($urandom_range(0, 3) == 0); is_shift = 1'($urandom);
      update_z_c = 1'($urandom); acode = 3'($urandom); scode = 2'($urandom);
      mem_addr = 8'($urandom_range(0, 15)); store_data = 8'($urandom);
      store_fwd = 8'($urandom); store_sel = 1'($urandom);
      mem_read = 1'($urandom); mem_write = 1'($urandom);
      do_cycle("rand");
    end

    clear_inputs();
    reg_a = 8'hFF; alu_src = 1; imm = 8'h01; update_z_c = 1;
    do_cycle("pre_rst");
    clear_inputs();
    mem_write = 1; mem_read = 1; mem_addr = 8'h11; store_data = 8'h77;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid.z", zero, 0);
    check_eq("rst_mid.c", carry, 0);
    check_eq("rst_mid.rdata", mem_rdata, 0);
    @(posedge clk);
    #1 check_eq("rst_held.rdata", mem_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_write = 0;
    for (int i = 0; i < 256; i++) mm[i] = 0;
    mz = 0; mc = 0;
    for (int i = 0; i < 256; i++) begin
      mem_addr = i[7:0];
      do_cycle("post_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
